// File: rtl/emern_rt_pkg.sv
// Shared widths, fixed-point format and FSM states for the
// triangle setup unit and its reciprocal divider.
package emern_rt_pkg;

    localparam int QM   = 23;
    localparam int QF   = 23;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int ZW   = 3;
    localparam int EXW  = XW + 1;
    localparam int EYW  = YW + 1;
    localparam int EZW  = ZW + 1;
    localparam int DIVQ = QM + 1;
    localparam int INVW = QM + QF;

    typedef enum logic [1:0] {
        IDLE,
        EDGE,
        DIV,
        DONE
    } state_e;

    // Cross product z term for a (0,0,-1) ray; operands sign-extended to QM
    function automatic logic signed [QM-1:0] tri_det(
        input logic signed [EXW-1:0] e1x,
        input logic signed [EYW-1:0] e1y,
        input logic signed [EXW-1:0] e2x,
        input logic signed [EYW-1:0] e2y
    );
        logic signed [QM-1:0] ax;
        logic signed [QM-1:0] ay;
        logic signed [QM-1:0] bx;
        logic signed [QM-1:0] by;
        ax = {{(QM-EXW){e1x[EXW-1]}}, e1x};
        ay = {{(QM-EYW){e1y[EYW-1]}}, e1y};
        bx = {{(QM-EXW){e2x[EXW-1]}}, e2x};
        by = {{(QM-EYW){e2y[EYW-1]}}, e2y};
        return ax * by - ay * bx;
    endfunction

endpackage

// File: rtl/emern_recip_div.sv
// Restoring divider computing floor(2^QF / divisor), one quotient
// bit per cycle; the first bit is resolved on the start edge.
module emern_recip_div
    import emern_rt_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [QM-1:0]   divisor,
    output logic            done,
    output logic [DIVQ-1:0] quotient
);

    logic          busy;
    logic [4:0]    cnt;
    logic [QM-1:0] rem;
    logic [QM-1:0] d_q;
    logic [QM:0]   shifted;
    logic [QM-1:0] dcur;
    logic [QM-1:0] rem_nxt;
    logic          qbit;

    // The dividend is 2^QF, so only the first step shifts in a one
    always_comb begin
        shifted = start ? {{QM{1'b0}}, 1'b1} : {rem, 1'b0};
        dcur    = start ? divisor : d_q;
        qbit    = shifted >= {1'b0, dcur};
        rem_nxt = qbit ? QM'(shifted - {1'b0, dcur})
                       : shifted[QM-1:0];
    end

    assign done = busy && (cnt == 5'(DIVQ - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            d_q      <= '0;
            quotient <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            cnt      <= 5'd1;
            d_q      <= divisor;
            rem      <= rem_nxt;
            quotient <= {{(DIVQ-1){1'b0}}, qbit};
        end else if (busy) begin
            rem      <= rem_nxt;
            quotient <= {quotient[DIVQ-2:0], qbit};
            cnt      <= cnt + 5'd1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/emern_triangle_setup.sv
// Triangle setup: edge vectors, determinant, back-face cull and
// reciprocal determinant in Q23.23, with valid/ready handshakes.
module emern_triangle_setup
    import emern_rt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XW-1:0]         v0_x,
    input  logic [XW-1:0]         v1_x,
    input  logic [XW-1:0]         v2_x,
    input  logic [YW-1:0]         v0_y,
    input  logic [YW-1:0]         v1_y,
    input  logic [YW-1:0]         v2_y,
    input  logic [ZW-1:0]         v0_z,
    input  logic [ZW-1:0]         v1_z,
    input  logic [ZW-1:0]         v2_z,
    output logic signed [EXW-1:0] edge_1_x,
    output logic signed [EYW-1:0] edge_1_y,
    output logic signed [EZW-1:0] edge_1_z,
    output logic signed [EXW-1:0] edge_2_x,
    output logic signed [EYW-1:0] edge_2_y,
    output logic signed [EZW-1:0] edge_2_z,
    output logic [XW-1:0]         vertex_0_x,
    output logic [YW-1:0]         vertex_0_y,
    output logic [ZW-1:0]         vertex_0_z,
    output logic [QM-1:0]         determinant,
    output logic [INVW-1:0]       inv_det,
    output logic                  cull,
    output logic                  out_valid,
    input  logic                  out_ready
);

    state_e state;
    state_e state_nxt;

    logic [XW-1:0] v1x_q, v2x_q;
    logic [YW-1:0] v1y_q, v2y_q;
    logic [ZW-1:0] v1z_q, v2z_q;

    logic signed [EXW-1:0] e1x_c, e2x_c;
    logic signed [EYW-1:0] e1y_c, e2y_c;
    logic signed [EZW-1:0] e1z_c, e2z_c;
    logic signed [QM-1:0]  det_c;
    logic signed [QM-1:0]  det_q;
    logic                  cull_c;
    logic                  cull_q;

    logic            div_start;
    logic            div_done;
    logic [QM-1:0]   div_divisor;
    logic [DIVQ-1:0] quot;

    assign e1x_c = $signed({1'b0, v1x_q} - {1'b0, vertex_0_x});
    assign e2x_c = $signed({1'b0, v2x_q} - {1'b0, vertex_0_x});
    assign e1y_c = $signed({1'b0, v1y_q} - {1'b0, vertex_0_y});
    assign e2y_c = $signed({1'b0, v2y_q} - {1'b0, vertex_0_y});
    assign e1z_c = $signed({1'b0, v1z_q} - {1'b0, vertex_0_z});
    assign e2z_c = $signed({1'b0, v2z_q} - {1'b0, vertex_0_z});

    assign det_c  = tri_det(e1x_c, e1y_c, e2x_c, e2y_c);
    assign cull_c = det_c[QM-1] || (det_c == '0);

    // Divide launches from the live determinant while leaving EDGE
    assign div_start   = (state == EDGE) && !cull_c;
    assign div_divisor = $unsigned(det_c);
    assign in_ready    = (state == IDLE);

    emern_recip_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .divisor  (div_divisor),
        .done     (div_done),
        .quotient (quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = EDGE;
            EDGE: state_nxt = cull_c ? DONE : DIV;
            DIV:  if (div_done) state_nxt = DONE;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vertex_0_x  <= '0;
            vertex_0_y  <= '0;
            vertex_0_z  <= '0;
            v1x_q       <= '0;
            v1y_q       <= '0;
            v1z_q       <= '0;
            v2x_q       <= '0;
            v2y_q       <= '0;
            v2z_q       <= '0;
            edge_1_x    <= '0;
            edge_1_y    <= '0;
            edge_1_z    <= '0;
            edge_2_x    <= '0;
            edge_2_y    <= '0;
            edge_2_z    <= '0;
            det_q       <= '0;
            cull_q      <= 1'b0;
            determinant <= '0;
            inv_det     <= '0;
            cull        <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                vertex_0_x <= v0_x;
                vertex_0_y <= v0_y;
                vertex_0_z <= v0_z;
                v1x_q      <= v1_x;
                v1y_q      <= v1_y;
                v1z_q      <= v1_z;
                v2x_q      <= v2_x;
                v2y_q      <= v2_y;
                v2z_q      <= v2_z;
            end
            if (state == EDGE) begin
                edge_1_x <= e1x_c;
                edge_1_y <= e1y_c;
                edge_1_z <= e1z_c;
                edge_2_x <= e2x_c;
                edge_2_y <= e2y_c;
                edge_2_z <= e2z_c;
                det_q    <= det_c;
                cull_q   <= cull_c;
            end
            // Result registers load once per triangle on DONE entry
            if (state == DONE && !out_valid) begin
                out_valid   <= 1'b1;
                cull        <= cull_q;
                determinant <= cull_q ? '0 : $unsigned(det_q);
                inv_det     <= cull_q ? '0
                             : {{(INVW-DIVQ){1'b0}}, quot};
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_emern_triangle_setup.sv
// Scoreboard bench for emern_triangle_setup: directed triangles,
// output hold, culling, divide bounds and mid-divide reset.
module tb_emern_triangle_setup;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [9:0]         v0_x, v1_x, v2_x;
    logic [8:0]         v0_y, v1_y, v2_y;
    logic [2:0]         v0_z, v1_z, v2_z;
    logic signed [10:0] edge_1_x, edge_2_x;
    logic signed [9:0]  edge_1_y, edge_2_y;
    logic signed [3:0]  edge_1_z, edge_2_z;
    logic [9:0]         vertex_0_x;
    logic [8:0]         vertex_0_y;
    logic [2:0]         vertex_0_z;
    logic [22:0]        determinant;
    logic [45:0]        inv_det;
    logic               cull;
    logic               out_valid;
    logic               out_ready;

    typedef struct {
        logic [9:0]         v0x;
        logic [8:0]         v0y;
        logic [2:0]         v0z;
        logic signed [10:0] e1x;
        logic signed [9:0]  e1y;
        logic signed [3:0]  e1z;
        logic signed [10:0] e2x;
        logic signed [9:0]  e2y;
        logic signed [3:0]  e2z;
        logic [22:0]        det;
        logic [45:0]        inv;
        logic               cl;
        int                 lat;
        int                 hold;
        int                 t;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    emern_triangle_setup dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .v0_x        (v0_x),
        .v1_x        (v1_x),
        .v2_x        (v2_x),
        .v0_y        (v0_y),
        .v1_y        (v1_y),
        .v2_y        (v2_y),
        .v0_z        (v0_z),
        .v1_z        (v1_z),
        .v2_z        (v2_z),
        .edge_1_x    (edge_1_x),
        .edge_1_y    (edge_1_y),
        .edge_1_z    (edge_1_z),
        .edge_2_x    (edge_2_x),
        .edge_2_y    (edge_2_y),
        .edge_2_z    (edge_2_z),
        .vertex_0_x  (vertex_0_x),
        .vertex_0_y  (vertex_0_y),
        .vertex_0_z  (vertex_0_z),
        .determinant (determinant),
        .inv_det     (inv_det),
        .cull        (cull),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic drive(input logic [9:0] ax, input logic [8:0] ay,
                         input logic [2:0] az, input logic [9:0] bx,
                         input logic [8:0] by, input logic [2:0] bz,
                         input logic [9:0] cx, input logic [8:0] cy,
                         input logic [2:0] cz);
        v0_x = ax; v0_y = ay; v0_z = az;
        v1_x = bx; v1_y = by; v1_z = bz;
        v2_x = cx; v2_y = cy; v2_z = cz;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(
        input logic [9:0] ax, input logic [8:0] ay, input logic [2:0] az,
        input logic [9:0] bx, input logic [8:0] by, input logic [2:0] bz,
        input logic [9:0] cx, input logic [8:0] cy, input logic [2:0] cz,
        input logic signed [10:0] e1x, input logic signed [9:0] e1y,
        input logic signed [3:0] e1z,
        input logic signed [10:0] e2x, input logic signed [9:0] e2y,
        input logic signed [3:0] e2z,
        input logic [22:0] det, input logic [45:0] inv, input logic cl,
        input int lat, input int hold, input bit junk);
        exp_t e;
        wait_ready();
        if (in_ready !== 1'b1) begin
            check("in_ready_wait", in_ready, 1);
            return;
        end
        drive(ax, ay, az, bx, by, bz, cx, cy, cz);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.v0x = ax; e.v0y = ay; e.v0z = az;
        e.e1x = e1x; e.e1y = e1y; e.e1z = e1z;
        e.e2x = e2x; e.e2y = e2y; e.e2z = e2z;
        e.det = det; e.inv = inv; e.cl = cl;
        e.lat = lat; e.hold = hold; e.t = cyc;
        sb.push_back(e);
        if (junk) begin
            drive(10'($urandom), 9'($urandom), 3'($urandom),
                  10'($urandom), 9'($urandom), 3'($urandom),
                  10'($urandom), 9'($urandom), 3'($urandom));
            repeat (5) @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || out_valid !== 1'b1) continue;
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
                @(negedge clk);
                continue;
            end
            e = sb.pop_front();
            check("latency", cyc - e.t, e.lat);
            check("edge_1_x", edge_1_x, e.e1x);
            check("edge_1_y", edge_1_y, e.e1y);
            check("edge_1_z", edge_1_z, e.e1z);
            check("edge_2_x", edge_2_x, e.e2x);
            check("edge_2_y", edge_2_y, e.e2y);
            check("edge_2_z", edge_2_z, e.e2z);
            check("vertex_0_x", vertex_0_x, e.v0x);
            check("vertex_0_y", vertex_0_y, e.v0y);
            check("vertex_0_z", vertex_0_z, e.v0z);
            check("determinant", determinant, e.det);
            check("inv_det", inv_det, e.inv);
            check("cull", cull, e.cl);
            if (e.hold > 0) begin
                out_ready = 1'b0;
                repeat (e.hold) begin
                    @(negedge clk);
                    check("hold_ctl", {in_ready, out_valid, cull},
                          {1'b0, 1'b1, e.cl});
                    check("hold_res", {determinant, inv_det[23:0]},
                          {e.det, e.inv[23:0]});
                    check("hold_edge", {edge_1_x, edge_2_y, vertex_0_x},
                          {e.e1x, e.e2y, e.v0x});
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            check("post_handshake", {out_valid, in_ready}, 2'b01);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin : stim
        int t0;
        int seen;
        int n;
        rst = 1'b1;
        in_valid = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_cull", cull, 0);
        check("rst_determinant", determinant, 0);
        check("rst_inv_det", inv_det, 0);
        rst = 1'b0;

        send(100, 50, 2, 300, 50, 5, 100, 250, 1,
             200, 0, 3, 0, 200, -1, 40000, 209, 0, 25, 0, 0);
        send(0, 0, 0, 10, 10, 0, 20, 20, 0,
             10, 10, 0, 20, 20, 0, 0, 0, 1, 2, 0, 0);
        send(100, 50, 2, 100, 250, 1, 300, 50, 5,
             0, 200, -1, 200, 0, 3, 0, 0, 1, 2, 0, 0);
        send(0, 0, 0, 1, 0, 0, 0, 1, 0,
             1, 0, 0, 0, 1, 0, 1, 8388608, 0, 25, 0, 0);
        send(100, 50, 2, 300, 50, 5, 100, 250, 1,
             200, 0, 3, 0, 200, -1, 40000, 209, 0, 25, 10, 0);
        send(0, 0, 7, 1023, 0, 0, 0, 511, 0,
             1023, 0, -7, 0, 511, -7, 522753, 16, 0, 25, 0, 0);
        send(10, 20, 0, 20, 20, 0, 10, 23, 0,
             10, 0, 0, 0, 3, 0, 30, 279620, 0, 25, 0, 1);

        // Abort a triangle mid-divide
        wait_ready();
        drive(100, 50, 2, 300, 50, 5, 100, 250, 1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        in_valid = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ctl", {out_valid, in_ready, cull}, 3'b010);
        check("abort_res", {determinant, inv_det[23:0]}, 0);
        check("abort_edge", {edge_1_x, edge_2_y, vertex_0_x}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("abort_no_output", seen, 0);

        send(100, 50, 2, 300, 50, 5, 100, 250, 1,
             200, 0, 3, 0, 200, -1, 40000, 209, 0, 25, 0, 0);

        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
